data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and `Data_mem`. It serves load hits combinationally with no stall. Load misses, and all stores, stall the pipeline while a single backing-memory transaction completes. It uses the same 3-bit `WE` access encoding as `Data_mem`, so the MEM stage sees an identical access interface plus a `stall` output.

---
 rtl/data_cache_if.sv | 26 ++
 rtl/data_cache.sv | 160 ++++++++++++++++
 tb/tb_data_cache.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Access bus between the MEM stage, data_cache and the backing Data_mem.
// The slave modport is the cache's view; master is the pipeline/memory side.
interface data_cache_if;
  logic        req_valid;
  logic [2:0]  WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        stall;
  logic        mem_req;
  logic [2:0]  mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
  logic        mem_ready;

  modport slave (
    input  req_valid, WE, A, WD, mem_RD, mem_ready,
    output RD, stall, mem_req, mem_WE, mem_A, mem_WD
  );

  modport master (
    output req_valid, WE, A, WD, mem_RD, mem_ready,
    input  RD, stall, mem_req, mem_WE, mem_A, mem_WD
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Define DCACHE_PERF_EN to add the hit_count / miss_count performance counters.
module data_cache #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int INDEX_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [2:0] WE_LW  = 3'b000;
  localparam logic [2:0] WE_LB  = 3'b010;
  localparam logic [2:0] WE_LBU = 3'b110;
  localparam logic [2:0] WE_SW  = 3'b001;
  localparam logic [2:0] WE_SB  = 3'b011;

  logic [1:0]           state;
  logic                 done;
  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tags  [LINES];
  logic [31:0]          words [LINES];

  logic [1:0]           offset;
  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0] tag;
  logic                 is_load;
  logic                 is_store;
  logic                 line_match;
  logic                 load_hit;
  logic [31:0]          line_word;
  logic [7:0]           sel_byte;
  logic [31:0]          store_word;
  logic                 unused_addr;

  assign offset      = bus.A[1:0];
  assign index       = bus.A[INDEX_WIDTH+1:2];
  assign tag         = bus.A[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
  assign unused_addr = ^bus.A[31:ADDRESS_WIDTH];

  assign is_load    = (bus.WE == WE_LW) || (bus.WE == WE_LB) || (bus.WE == WE_LBU);
  assign is_store   = (bus.WE == WE_SW) || (bus.WE == WE_SB);
  assign line_match = valid[index] && (tags[index] == tag);
  assign load_hit   = bus.req_valid && is_load && line_match;

  // done marks the cycle in which the store just written is released.
  assign bus.stall = bus.req_valid && (is_load || is_store) && !load_hit && !done;

  assign line_word = words[index];
  assign sel_byte  = line_word[{offset, 3'b000} +: 8];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    bus.RD = '0;
    if (load_hit) begin
      unique case (bus.WE)
        WE_LW:   bus.RD = line_word;
        WE_LB:   bus.RD = {{24{sel_byte[7]}}, sel_byte};
        WE_LBU:  bus.RD = {24'h0, sel_byte};
        default: bus.RD = '0;
      endcase
    end
  end

  always_comb begin
    store_word = line_word;
    if (bus.WE == WE_SW) store_word = bus.WD;
    else                 store_word[{offset, 3'b000} +: 8] = bus.WD[7:0];
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      valid       <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_WE  <= 3'b000;
      bus.mem_A   <= '0;
      bus.mem_WD  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.stall) begin
            bus.mem_req <= 1'b1;
            if (is_load) begin
              bus.mem_WE <= WE_LW;
              bus.mem_A  <= {bus.A[31:2], 2'b00};
              bus.mem_WD <= '0;
              state      <= FILL;
            end else begin
              bus.mem_WE <= bus.WE;
              bus.mem_A  <= bus.A;
              bus.mem_WD <= bus.WD;
              state      <= WRITE;
            end
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            bus.mem_req  <= 1'b0;
            valid[index] <= 1'b1;
            state        <= IDLE;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data storage carries no reset; the valid bits alone decide whether a line means anything.
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_ready) begin
      if (state == FILL) begin
        tags[index]  <= tag;
        words[index] <= bus.mem_RD;
      end else if (state == WRITE && line_match) begin
        words[index] <= store_word;
      end
    end
  end

`ifdef DCACHE_PERF_EN
  // A hit counts only if the request was not held on the previous cycle, so a post-fill hit is not counted.
  logic was_stalled;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      was_stalled <= 1'b0;
    end else begin
      was_stalled <= bus.stall;
      if (load_hit && !was_stalled) hit_count <= hit_count + 32'd1;
      if (state == IDLE && bus.stall && is_load) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a transaction-level cache/memory model
// produces per-cycle expectations, checked every cycle on the falling edge.
module tb_data_cache;

  localparam logic [2:0] LW = 3'b000, LB = 3'b010, LBU = 3'b110, SW = 3'b001, SB = 3'b011;

  typedef struct {
    bit          stall;
    logic [31:0] rd;
    bit          req;
    logic [2:0]  we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk_wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus ();

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
  data_cache dut (.clk(clk), .rst(rst), .bus(bus.slave), .hit_count(hit_count), .miss_count(miss_count));
`else
  data_cache dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cache lines and backing memory (word-addressed by A[16:2]).
  bit          m_valid [16];
  logic [10:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] bmem [int unsigned];
  int          m_hits  = 0;
  int          m_fills = 0;

  exp_t        ex;
  bit          chk_en = 1'b0;
  int          stall_total = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'h0, bus.stall}, {31'h0, ex.stall});
      check("RD", bus.RD, ex.rd);
      check("mem_req", {31'h0, bus.mem_req}, {31'h0, ex.req});
      if (ex.req) begin
        check("mem_WE", {29'h0, bus.mem_WE}, {29'h0, ex.we});
        check("mem_A", bus.mem_A, ex.a);
        if (ex.chk_wd) check("mem_WD", bus.mem_WD, ex.wd);
      end
      if (bus.stall) stall_total++;
      last_rd = bus.RD;
    end
  end

  function automatic exp_t mk(input bit stall, input logic [31:0] rd, input bit req,
                              input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd,
                              input bit chk_wd);
    exp_t e;
    e.stall = stall; e.rd = rd; e.req = req; e.we = we; e.a = a; e.wd = wd; e.chk_wd = chk_wd;
    return e;
  endfunction

  function automatic logic [31:0] bget(input logic [14:0] wa);
    if (bmem.exists(int'(wa))) return bmem[int'(wa)];
    return {17'h1ACE5, wa};
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] we, input logic [1:0] off);
    logic [7:0] b;
    b = 8'(w >> (8 * off));
    case (we)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] we,
                                        input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] m;
    if (we == SW) return wd;
    m = 32'hFF << (8 * off);
    return (old & ~m) | (32'(wd[7:0]) << (8 * off));
  endfunction

  task automatic drive(input bit rv, input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd,
                       input bit rdy, input logic [31:0] rdata, input exp_t e);
    @(posedge clk); #1;
    bus.req_valid = rv; bus.WE = we; bus.A = a; bus.WD = wd;
    bus.mem_ready = rdy; bus.mem_RD = rdata;
    ex = e; chk_en = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_fills = 0;
  endtask

  task automatic do_reset(input int cycles);
    chk_en = 1'b0; rst = 1'b1;
    bus.req_valid = 1'b0; bus.WE = LW; bus.A = '0; bus.WD = '0;
    bus.mem_ready = 1'b0; bus.mem_RD = '0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One complete MEM-stage access; delay = cycles from mem_req to mem_ready inclusive.
  task automatic access(input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, output int stalls, output logic [31:0] rd_out);
    int          s0 = stall_total;
    logic [3:0]  idx = a[5:2];
    logic [10:0] tg  = a[16:6];
    logic [14:0] wa  = a[16:2];
    bit          ld  = (we == LW) || (we == LB) || (we == LBU);
    bit          st  = (we == SW) || (we == SB);
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    if (ld && hit) begin
      drive(1, we, a, wd, 0, '0, mk(0, load_val(m_data[idx], we, a[1:0]), 0, LW, '0, '0, 0));
      m_hits++;
    end else if (ld) begin
      drive(1, we, a, wd, 0, '0, mk(1, '0, 0, LW, '0, '0, 0));
      m_fills++;
      for (int k = 1; k <= delay; k++)
        drive(1, we, a, wd, k == delay, bget(wa), mk(1, '0, 1, LW, {a[31:2], 2'b00}, '0, 0));
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = bget(wa);
      drive(1, we, a, wd, 0, '0, mk(0, load_val(m_data[idx], we, a[1:0]), 0, LW, '0, '0, 0));
    end else if (st) begin
      drive(1, we, a, wd, 0, '0, mk(1, '0, 0, LW, '0, '0, 0));
      for (int k = 1; k <= delay; k++)
        drive(1, we, a, wd, k == delay, 32'hBADC0DE0, mk(1, '0, 1, we, a, wd, 1));
      bmem[int'(wa)] = merge(bget(wa), we, a[1:0], wd);
      if (hit) m_data[idx] = merge(m_data[idx], we, a[1:0], wd);
      drive(1, we, a, wd, 0, '0, mk(0, '0, 0, LW, '0, '0, 0));
    end else begin
      drive(1, we, a, wd, 0, '0, mk(0, '0, 0, LW, '0, '0, 0));
    end
    @(negedge clk); #1;
    stalls = stall_total - s0;
    rd_out = last_rd;
  endtask

  int          stalls;
  logic [31:0] rd;

  initial begin
    bmem[int'(15'h0040)] = 32'hDEADBEEF;  // word at 0x100
    do_reset(3);

    // Reset state with no request.
    drive(0, LW, '0, '0, 0, '0, mk(0, '0, 0, LW, '0, '0, 0));
    @(negedge clk); #1;
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_WE", {29'h0, bus.mem_WE}, 32'h0);
    check("rst_mem_A", bus.mem_A, 32'h0);
    check("rst_mem_WD", bus.mem_WD, 32'h0);

    // Cold lw miss with mem_ready delay 2, then a repeat hit.
    access(LW, 32'h100, '0, 2, stalls, rd);
    check("lw_miss_stall_cycles", stalls, 3);
    check("lw_miss_rd", rd, 32'hDEADBEEF);
    access(LW, 32'h100, '0, 2, stalls, rd);
    check("lw_hit_stall_cycles", stalls, 0);
    check("lw_hit_rd", rd, 32'hDEADBEEF);

    // Byte loads from the filled line.
    access(LB, 32'h103, '0, 1, stalls, rd);
    check("lb_103", rd, 32'hFFFFFFDE);
    check("lb_103_stall", stalls, 0);
    access(LBU, 32'h103, '0, 1, stalls, rd);
    check("lbu_103", rd, 32'h000000DE);
    access(LB, 32'h100, '0, 1, stalls, rd);
    check("lb_100", rd, 32'hFFFFFFEF);
    access(LBU, 32'h101, '0, 1, stalls, rd);
    check("lbu_101", rd, 32'h000000BE);

    // sb hit updates the cached byte.
    access(SB, 32'h101, 32'h00000055, 3, stalls, rd);
    access(LW, 32'h100, '0, 1, stalls, rd);
    check("lw_after_sb", rd, 32'hDEAD55EF);
    check("lw_after_sb_stall", stalls, 0);

    // sw hit updates the whole word.
    access(SW, 32'h100, 32'hCAFEF00D, 1, stalls, rd);
    access(LW, 32'h100, '0, 1, stalls, rd);
    check("lw_after_sw_hit", rd, 32'hCAFEF00D);

    // Upper address bits beyond ADDRESS_WIDTH are ignored.
    access(LW, 32'hFFFE0100, '0, 1, stalls, rd);
    check("upper_bits_ignored", rd, 32'hCAFEF00D);

    // sw miss does not allocate; the following lw misses (index 0 also holds 0x100).
    access(SW, 32'h2000, 32'h12345678, 1, stalls, rd);
    access(LW, 32'h2000, '0, 2, stalls, rd);
    check("no_allocate_stall_cycles", stalls, 3);
    check("no_allocate_rd", rd, 32'h12345678);

    // Same index, different tags: each evicts the other.
    access(LW, 32'h100, '0, 1, stalls, rd);
    check("conflict_100_stall", stalls, 2);
    access(LW, 32'h140, '0, 1, stalls, rd);
    check("conflict_140_stall", stalls, 2);
    access(LW, 32'h100, '0, 1, stalls, rd);
    check("conflict_100_again", stalls, 2);
    check("conflict_100_rd", rd, 32'hCAFEF00D);

    // Another index, all byte offsets, plus invalid code and idle mem_ready.
    access(LW, 32'h1F4, '0, 4, stalls, rd);
    for (int o = 0; o < 4; o++) begin
      access(LB, 32'h1F4 + 32'(o), '0, 1, stalls, rd);
      access(LBU, 32'h1F4 + 32'(o), '0, 1, stalls, rd);
    end
    access(3'b100, 32'h100, 32'h1, 1, stalls, rd);
    check("invalid_we_stall", stalls, 0);
    drive(0, LW, 32'h180, '0, 1, 32'h77777777, mk(0, '0, 0, LW, '0, '0, 0));
    access(LW, 32'h180, '0, 1, stalls, rd);
    check("ready_without_req_ignored", stalls, 2);

    // Reset in the middle of a fill.
    access(LW, 32'h300, '0, 1, stalls, rd);
    drive(1, LW, 32'h1C0, '0, 0, '0, mk(1, '0, 0, LW, '0, '0, 0));
    drive(1, LW, 32'h1C0, '0, 0, '0, mk(1, '0, 1, LW, 32'h1C0, '0, 0));
    @(posedge clk); #1;
    chk_en = 1'b0; rst = 1'b1; bus.mem_ready = 1'b1; bus.mem_RD = 32'hBAD0BAD0;
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ready = 1'b0; bus.req_valid = 1'b0;
    model_reset();
    ex = mk(0, '0, 0, LW, '0, '0, 0); chk_en = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_fill_mem_req", {31'h0, bus.mem_req}, 32'h0);
    access(LW, 32'h1C0, '0, 1, stalls, rd);
    check("rst_mid_fill_refetch", stalls, 2);
    access(LW, 32'h300, '0, 1, stalls, rd);
    check("rst_invalidates_all", stalls, 2);

`ifdef DCACHE_PERF_EN
    check("hit_count", hit_count, 32'(m_hits));
    check("miss_count", miss_count, 32'(m_fills));
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
